mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port memory arbiter with fetch anti-starvation and access timeout
// Data side wins ties until the fetch side has lost STARVE_LIMIT in a row.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int TIMEOUT      = 8,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 err,
  output logic [WORD_SIZE-1:0] num_i_access,
  output logic [WORD_SIZE-1:0] num_d_access
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] num_i_q, num_i_d;
  logic [WORD_SIZE-1:0] num_d_q, num_d_d;
  logic                 busy, timeout, done;

  // A timeout completes the access like a real ack, but with zero data.
  assign busy    = (state_q != IDLE);
  assign timeout = busy && !mem_ack && (wait_q == WW'(TIMEOUT - 1));
  assign done    = busy && (mem_ack || timeout);

  assign i_ack   = (state_q == BUSY_I) && done;
  assign d_ack   = (state_q == BUSY_D) && done;
  assign i_rdata = ((state_q == BUSY_I) && mem_ack) ? mem_rdata : '0;
  assign d_rdata = ((state_q == BUSY_D) && mem_ack) ? mem_rdata : '0;
  assign i_stall = i_req && !i_ack;
  assign d_stall = d_req && !d_ack;

  assign mem_req      = busy;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign err          = err_q;
  assign num_i_access = num_i_q;
  assign num_d_access = num_d_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    err_d    = err_q || timeout;
    num_i_d  = i_ack ? num_i_q + WORD_SIZE'(1) : num_i_q;
    num_d_d  = d_ack ? num_d_q + WORD_SIZE'(1) : num_d_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || (starve_q < SW'(STARVE_LIMIT)))) begin
          state_d = BUSY_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          wait_d  = '0;
          if (i_req) starve_d = starve_q + SW'(1);
        end else if (i_req) begin
          state_d  = BUSY_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wait_d   = '0;
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) state_d = IDLE;
        else      wait_d  = wait_q + WW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      num_i_q  <= '0;
      num_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
      num_i_q  <= num_i_d;
      num_d_q  <= num_d_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// An 8-bit instance exercises counter wrap within a short run.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, i_stall, d_ack, d_stall, mem_req, mem_we, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, num_i_access, num_d_access;

  logic        d_req8, mem_ack8;
  logic        i_ack8, i_stall8, d_ack8, d_stall8, mem_req8, mem_we8, err8;
  logic [7:0]  i_rdata8, d_rdata8, mem_addr8, mem_wdata8, num_i8, num_d8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err),
    .num_i_access(num_i_access), .num_d_access(num_d_access)
  );

  mem_port_arbiter #(.WORD_SIZE(8)) dut8 (
    .clk(clk), .reset(reset),
    .i_req(1'b0), .i_addr(8'h00), .i_ack(i_ack8), .i_rdata(i_rdata8), .i_stall(i_stall8),
    .d_req(d_req8), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00),
    .d_ack(d_ack8), .d_rdata(d_rdata8), .d_stall(d_stall8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_rdata(8'h00), .mem_ack(mem_ack8), .err(err8),
    .num_i_access(num_i8), .num_d_access(num_d8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic exp_d [6];

  initial begin
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b0;
    exp_d[3] = 1'b1; exp_d[4] = 1'b1; exp_d[5] = 1'b0;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    d_req8 = 1'b0; mem_ack8 = 1'b0;

    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err, 0);
    check("rst_num_i", num_i_access, 0);
    check("rst_num_d", num_d_access, 0);
    i_req = 1'b1; mem_ack = 1'b1;
    #1;
    check("rst_i_ack", i_ack, 0);
    check("rst_i_stall", i_stall, 1);
    i_req = 1'b0; mem_ack = 1'b0;

    @(negedge clk); reset = 1'b0;

    // single fetch
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0010;
    #1;
    check("t1_idle_mem_req", mem_req, 0);
    check("t1_stall_wait", i_stall, 1);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    #1;
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 16'h0010);
    check("t1_mem_we", mem_we, 0);
    check("t1_i_ack", i_ack, 1);
    check("t1_i_rdata", i_rdata, 16'hA5A5);
    check("t1_stall_ack", i_stall, 0);
    @(negedge clk); i_req = 1'b0; mem_ack = 1'b0;
    #1;
    check("t1_num_i", num_i_access, 1);
    check("t1_i_ack_off", i_ack, 0);
    check("t1_i_rdata_off", i_rdata, 0);
    check("t1_idle", mem_req, 0);

    // mem_ack while idle
    @(negedge clk); mem_ack = 1'b1;
    #1;
    check("idle_ack_i", i_ack, 0);
    check("idle_ack_d", d_ack, 0);
    @(negedge clk); mem_ack = 1'b0;
    #1;
    check("idle_num_i", num_i_access, 1);
    check("idle_num_d", num_d_access, 0);
    check("idle_mem_req", mem_req, 0);

    // simultaneous requests, data write first
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1;
    check("t2_d_ack", d_ack, 1);
    check("t2_i_ack", i_ack, 0);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 16'h0020);
    check("t2_mem_wdata", mem_wdata, 16'h1234);
    check("t2_i_stall", i_stall, 1);
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    #1;
    check("t2_idle", mem_req, 0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    check("t2_i_ack2", i_ack, 1);
    check("t2_i_rdata", i_rdata, 16'hBEEF);
    check("t2_i_addr", mem_addr, 16'h0030);
    check("t2_i_we", mem_we, 0);
    check("t2_i_wdata", mem_wdata, 0);
    @(negedge clk); i_req = 1'b0; mem_ack = 1'b0;

    // continuous contention: D, D, I, D, D, I
    i_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h0 + 16'(k);
      #1;
      check("t3_d_ack", d_ack, {31'b0, exp_d[k]});
      check("t3_i_ack", i_ack, {31'b0, !exp_d[k]});
      check("t3_addr", mem_addr, exp_d[k] ? 32'h0200 : 32'h0100);
      @(negedge clk); mem_ack = 1'b0;
      if (k == 5) begin i_req = 1'b0; d_req = 1'b0; end
    end
    #1;
    check("t3_num_i", num_i_access, 4);
    check("t3_num_d", num_d_access, 5);

    // timeout on a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      check("t4_d_ack", d_ack, (c == 8) ? 1 : 0);
      check("t4_err_pre", err, 0);
      if (c == 8) check("t4_d_rdata", d_rdata, 0);
    end
    @(negedge clk); d_req = 1'b0; i_req = 1'b1; i_addr = 16'h0050;
    #1;
    check("t4_err", err, 1);
    check("t4_idle", mem_req, 0);
    check("t4_num_d", num_d_access, 6);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h1111;
    #1;
    check("t4_i_ack", i_ack, 1);
    check("t4_i_addr", mem_addr, 16'h0050);
    check("t4_i_rdata", i_rdata, 16'h1111);
    @(negedge clk); i_req = 1'b0; mem_ack = 1'b0;
    #1;
    check("t4_err_sticky", err, 1);
    check("t4_num_i", num_i_access, 5);

    // reset in the middle of a data write
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h5555;
    @(negedge clk);
    #1;
    check("t5_busy", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_mem_req", mem_req, 0);
    check("t5_d_ack", d_ack, 0);
    check("t5_num_i", num_i_access, 0);
    check("t5_num_d", num_d_access, 0);
    check("t5_err", err, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_d_stall", d_stall, 1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); mem_ack = 1'b1;
    #1;
    check("t5_regrant", mem_req, 1);
    check("t5_regrant_addr", mem_addr, 16'h0060);
    check("t5_d_ack2", d_ack, 1);
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    #1;
    check("t5_num_d2", num_d_access, 1);

    // counter wrap on the narrow instance
    @(negedge clk); d_req8 = 1'b1; mem_ack8 = 1'b1;
    repeat (510) @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_num_d_max", num_d8, 8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk); d_req8 = 1'b0; mem_ack8 = 1'b0;
    #1;
    check("t6_num_d_wrap", num_d8, 0);
    check("t6_num_i", num_i8, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
